// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus controller: state encodings, default
// timing and the a_d phase encodings.
package rtc_bus_pkg;

   localparam int STATE_W = 4;

   localparam logic [STATE_W-1:0] IDLE = 4'd0;
   localparam logic [STATE_W-1:0] A_SU = 4'd1;
   localparam logic [STATE_W-1:0] A_PW = 4'd2;
   localparam logic [STATE_W-1:0] A_HD = 4'd3;
   localparam logic [STATE_W-1:0] GAP  = 4'd4;
   localparam logic [STATE_W-1:0] D_SU = 4'd5;
   localparam logic [STATE_W-1:0] D_PW = 4'd6;
   localparam logic [STATE_W-1:0] D_HD = 4'd7;
   localparam logic [STATE_W-1:0] DONE = 4'd8;

   localparam int T_SU_DEF  = 2;
   localparam int T_PW_DEF  = 4;
   localparam int T_HD_DEF  = 2;
   localparam int T_GAP_DEF = 4;
   localparam int CNT_W_DEF = 8;

   localparam logic ADDR_PHASE = 1'b0;
   localparam logic DATA_PHASE = 1'b1;

endpackage

// File: rtl/rtc_bus_controller_if.sv
// Request/response handshake between the control FSMs and the RTC bus
// controller. A request is accepted when req=1 while busy=0 (IDLE); busy then
// stays high through the one-cycle done pulse, and further reqs are dropped.
interface rtc_bus_controller_if;
   logic       req;
   logic       wr;
   logic [7:0] address;
   logic [7:0] data_wr;
   logic [7:0] data_rd;
   logic       busy;
   logic       done;

   modport master (output req, wr, address, data_wr,
                   input  data_rd, busy, done);

   modport slave  (input  req, wr, address, data_wr,
                   output data_rd, busy, done);
endinterface

// File: rtl/rtc_bus_controller_phase_timer.sv
// Loadable down-counter timing each controller state; expire is high in the
// last cycle of the state. A load value of 0 behaves as 1.
module phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             expire
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= (load_value == '0) ? '0 : load_value - CNT_W'(1);
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/rtc_bus_controller.sv
// Runs each accepted request as an address phase followed by a data phase on
// the RTC's multiplexed bus; all pin outputs are registered.
module rtc_bus_controller
   import rtc_bus_pkg::*;
#(
   parameter int T_SU  = T_SU_DEF,
   parameter int T_PW  = T_PW_DEF,
   parameter int T_HD  = T_HD_DEF,
   parameter int T_GAP = T_GAP_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               Reset,
   rtc_bus_controller_if.slave bus,
   output logic               cs_n,
   output logic               a_d,
   output logic               wr_n,
   output logic               rd_n,
   inout  wire  [7:0]         ad,
   output logic [STATE_W-1:0] dbg_state
);

   logic [STATE_W-1:0] state, state_next;
   logic               expire, load;
   logic [CNT_W-1:0]   load_value;

   logic       wr_l;
   logic [7:0] addr_l, data_l;
   logic       cur_wr;
   logic [7:0] cur_addr, cur_data;

   logic       cs_n_d, a_d_d, wr_n_d, rd_n_d, ad_oe_d, busy_d, done_d;
   logic [7:0] ad_out_d;
   logic       ad_oe, busy_q, done_q;
   logic [7:0] ad_out, data_rd_q;

   function automatic logic [CNT_W-1:0] state_cycles(input logic [STATE_W-1:0] s);
      case (s)
         A_SU, D_SU: state_cycles = CNT_W'(T_SU);
         A_PW, D_PW: state_cycles = CNT_W'(T_PW);
         A_HD, D_HD: state_cycles = CNT_W'(T_HD);
         GAP:        state_cycles = CNT_W'(T_GAP);
         default:    state_cycles = CNT_W'(1);
      endcase
   endfunction

   // Timer restarts on every state entry with the duration of the new state.
   assign load       = (state_next != state);
   assign load_value = state_cycles(state_next);

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .Reset      (Reset),
      .load       (load),
      .load_value (load_value),
      .expire     (expire)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req) state_next = A_SU;
         A_SU:    if (expire)  state_next = A_PW;
         A_PW:    if (expire)  state_next = A_HD;
         A_HD:    if (expire)  state_next = GAP;
         GAP:     if (expire)  state_next = D_SU;
         D_SU:    if (expire)  state_next = D_PW;
         D_PW:    if (expire)  state_next = D_HD;
         D_HD:    if (expire)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // On the accept edge the latches are not loaded yet, so use the live inputs.
   assign cur_wr   = (state == IDLE) ? bus.wr      : wr_l;
   assign cur_addr = (state == IDLE) ? bus.address : addr_l;
   assign cur_data = (state == IDLE) ? bus.data_wr : data_l;

   always_comb begin
      cs_n_d   = 1'b1;
      a_d_d    = DATA_PHASE;
      wr_n_d   = 1'b1;
      rd_n_d   = 1'b1;
      ad_oe_d  = 1'b0;
      ad_out_d = 8'h00;
      case (state_next)
         A_SU, A_HD: begin
            cs_n_d   = 1'b0;
            a_d_d    = ADDR_PHASE;
            ad_oe_d  = 1'b1;
            ad_out_d = cur_addr;
         end
         A_PW: begin
            cs_n_d   = 1'b0;
            a_d_d    = ADDR_PHASE;
            wr_n_d   = 1'b0;
            ad_oe_d  = 1'b1;
            ad_out_d = cur_addr;
         end
         D_SU, D_HD: begin
            cs_n_d   = 1'b0;
            ad_oe_d  = cur_wr;
            ad_out_d = cur_data;
         end
         D_PW: begin
            cs_n_d   = 1'b0;
            wr_n_d   = !cur_wr;
            rd_n_d   = cur_wr;
            ad_oe_d  = cur_wr;
            ad_out_d = cur_data;
         end
         default: ;
      endcase
      busy_d = (state_next != IDLE);
      done_d = (state_next == DONE);
   end

   always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         cs_n      <= 1'b1;
         a_d       <= DATA_PHASE;
         wr_n      <= 1'b1;
         rd_n      <= 1'b1;
         ad_oe     <= 1'b0;
         ad_out    <= 8'h00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         data_rd_q <= 8'h00;
         wr_l      <= 1'b0;
         addr_l    <= 8'h00;
         data_l    <= 8'h00;
      end else begin
         state  <= state_next;
         cs_n   <= cs_n_d;
         a_d    <= a_d_d;
         wr_n   <= wr_n_d;
         rd_n   <= rd_n_d;
         ad_oe  <= ad_oe_d;
         ad_out <= ad_out_d;
         busy_q <= busy_d;
         done_q <= done_d;
         if (state == IDLE && bus.req) begin
            wr_l   <= bus.wr;
            addr_l <= bus.address;
            data_l <= bus.data_wr;
         end
         // Read data is captured on the edge that ends the last strobe cycle.
         if (state == D_PW && expire && !wr_l) begin
            data_rd_q <= ad;
         end
      end
   end

   assign ad          = ad_oe ? ad_out : 8'hzz;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.data_rd = data_rd_q;
   assign dbg_state   = state;

endmodule

// File: tb/tb_rtc_bus_controller.sv
// Directed bench for rtc_bus_controller: default-timing DUT plus a DUT with
// all timing parameters at their clamped minimum.
module tb_rtc_bus_controller;

  localparam int T_SU  = 2;
  localparam int T_PW  = 4;
  localparam int T_HD  = 2;
  localparam int T_GAP = 4;
  localparam int LAT_A = 2 * (T_SU + T_PW + T_HD) + T_GAP + 1;  // 21
  localparam int LAT_B = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset = 1'b0;
  always #5 clk = ~clk;

  rtc_bus_controller_if if_a ();
  rtc_bus_controller_if if_b ();

  logic       a_cs_n, a_a_d, a_wr_n, a_rd_n;
  logic       b_cs_n, b_a_d, b_wr_n, b_rd_n;
  wire  [7:0] ad_a, ad_b;
  logic [3:0] a_state, b_state;
  logic [7:0] rtc_val = 8'h00;

  // RTC model: drives read data while its read strobe is low.
  assign ad_a = (!a_rd_n && !a_cs_n) ? rtc_val : 8'hzz;
  assign ad_b = (!b_rd_n && !b_cs_n) ? rtc_val : 8'hzz;

  rtc_bus_controller dut_a (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (if_a.slave),
    .cs_n      (a_cs_n),
    .a_d       (a_a_d),
    .wr_n      (a_wr_n),
    .rd_n      (a_rd_n),
    .ad        (ad_a),
    .dbg_state (a_state)
  );

  rtc_bus_controller #(.T_SU(0), .T_PW(1), .T_HD(0), .T_GAP(0)) dut_b (
    .clk       (clk),
    .Reset     (Reset),
    .bus       (if_b.slave),
    .cs_n      (b_cs_n),
    .a_d       (b_a_d),
    .wr_n      (b_wr_n),
    .rd_n      (b_rd_n),
    .ad        (ad_b),
    .dbg_state (b_state)
  );

  // observed DUT selected by sel
  logic       sel = 1'b0;
  logic       m_cs_n, m_a_d, m_wr_n, m_rd_n, m_busy, m_done;
  logic [7:0] m_ad, m_data_rd;
  assign m_cs_n    = sel ? b_cs_n : a_cs_n;
  assign m_a_d     = sel ? b_a_d : a_a_d;
  assign m_wr_n    = sel ? b_wr_n : a_wr_n;
  assign m_rd_n    = sel ? b_rd_n : a_rd_n;
  assign m_busy    = sel ? if_b.busy : if_a.busy;
  assign m_done    = sel ? if_b.done : if_a.done;
  assign m_ad      = sel ? ad_b : ad_a;
  assign m_data_rd = sel ? if_b.data_rd : if_a.data_rd;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // bus rule monitor on both DUTs
  int   viol = 0;
  logic pa_ad = 1'b1, pa_wr = 1'b1, pa_rd = 1'b1;
  logic pb_ad = 1'b1, pb_wr = 1'b1, pb_rd = 1'b1;
  always @(negedge clk) begin
    if (Reset) begin
      if (!a_wr_n && !a_rd_n) viol++;
      if ((!a_wr_n || !a_rd_n) && a_cs_n) viol++;
      if (a_a_d != pa_ad && !(a_wr_n && a_rd_n && pa_wr && pa_rd)) viol++;
      if (!b_wr_n && !b_rd_n) viol++;
      if ((!b_wr_n || !b_rd_n) && b_cs_n) viol++;
      if (b_a_d != pb_ad && !(b_wr_n && b_rd_n && pb_wr && pb_rd)) viol++;
    end
    pa_ad = a_a_d; pa_wr = a_wr_n; pa_rd = a_rd_n;
    pb_ad = b_a_d; pb_wr = b_wr_n; pb_rd = b_rd_n;
  end

  // ---------------- driver tasks ----------------
  int         done_cnt, done_cyc, busy_cnt, a_cnt, dw_cnt, dr_cnt, cs_hi_busy;
  logic [7:0] rd_at_done;

  task automatic set_req(input logic v);
    if (sel) if_b.req = v;
    else     if_a.req = v;
  endtask

  task automatic run_txn(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] rtc, input int len, input bit chg, input bit pulse);
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; a_cnt = 0;
    dw_cnt = 0; dr_cnt = 0; cs_hi_busy = 0; rd_at_done = 8'h00;
    @(negedge clk);
    if_a.wr = w; if_a.address = a; if_a.data_wr = d;
    if_b.wr = w; if_b.address = a; if_b.data_wr = d;
    rtc_val = rtc;
    set_req(1'b1);
    @(negedge clk);
    set_req(1'b0);
    for (int c = 1; c <= len; c++) begin
      if (m_busy) busy_cnt++;
      if (m_done) begin
        done_cnt++;
        if (done_cyc == 0) begin
          done_cyc   = c;
          rd_at_done = m_data_rd;
        end
      end
      if (!m_cs_n && m_a_d == 1'b0 && !m_wr_n && m_ad == a) a_cnt++;
      if (!m_cs_n && m_a_d == 1'b1 && !m_wr_n && m_ad == d) dw_cnt++;
      if (!m_cs_n && m_a_d == 1'b1 && !m_rd_n && m_ad == rtc) dr_cnt++;
      if (m_busy && m_cs_n) cs_hi_busy++;
      if (chg && c == 1) begin
        if_a.wr = ~w; if_a.address = ~a; if_a.data_wr = ~d;
      end
      if (pulse && (c == 5 || c == LAT_A)) set_req(1'b1);
      if (pulse && (c == 6 || c == LAT_A + 1)) set_req(1'b0);
      @(negedge clk);
    end
  endtask

  task automatic check_txn(input string tag, input int lat, input int pw, input int gap, input logic w);
    logic [7:0] exp_rd;
    exp_rd = exp_q.pop_front();
    check({tag, " done_cycle"}, done_cyc, lat);
    check({tag, " done_count"}, done_cnt, 1);
    check({tag, " busy_cycles"}, busy_cnt, lat);
    check({tag, " addr_strobe"}, a_cnt, pw);
    check({tag, " data_wr_strobe"}, dw_cnt, w ? pw : 0);
    check({tag, " data_rd_strobe"}, dr_cnt, w ? 0 : pw);
    check({tag, " cs_high_busy"}, cs_hi_busy, gap + 1);
    check({tag, " data_rd"}, rd_at_done, exp_rd);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] rtc;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int idle_bad;
    int b2b_done, b2b_second, b2b_idle;
    bit drained;

    vecs[0] = '{w: 1'b1, a: 8'h00, d: 8'h10, rtc: 8'h00, exp_rd: 8'h00};
    vecs[1] = '{w: 1'b0, a: 8'h21, d: 8'h86, rtc: 8'h59, exp_rd: 8'h59};
    vecs[2] = '{w: 1'b1, a: 8'h3C, d: 8'hA5, rtc: 8'h00, exp_rd: 8'h59};
    vecs[3] = '{w: 1'b0, a: 8'h7F, d: 8'h00, rtc: 8'hC3, exp_rd: 8'hC3};
    vecs[4] = '{w: 1'b1, a: 8'hFF, d: 8'hFF, rtc: 8'h00, exp_rd: 8'hC3};

    if_a.req = 1'b0; if_a.wr = 1'b0; if_a.address = 8'h00; if_a.data_wr = 8'h00;
    if_b.req = 1'b0; if_b.wr = 1'b0; if_b.address = 8'h00; if_b.data_wr = 8'h00;

    // reset and idle
    repeat (3) @(negedge clk);
    check("reset pins", {a_cs_n, a_wr_n, a_rd_n, a_a_d, if_a.busy, if_a.done}, 6'b111100);
    check("reset data_rd", if_a.data_rd, 8'h00);
    Reset = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({a_cs_n, a_wr_n, a_rd_n, a_a_d, if_a.busy, if_a.done} != 6'b111100) idle_bad++;
      if (if_a.data_rd != 8'h00) idle_bad++;
    end
    check("idle pins", idle_bad, 0);

    // table-driven transactions on default-timing DUT
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].exp_rd);
      run_txn(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].rtc, 30, 1'b0, 1'b0);
      check_txn($sformatf("vec%0d", i), LAT_A, T_PW, T_GAP, vecs[i].w);
    end

    // input change after accept
    exp_q.push_back(8'hC3);
    run_txn(1'b1, 8'h42, 8'h24, 8'h00, 30, 1'b1, 1'b0);
    check_txn("chg", LAT_A, T_PW, T_GAP, 1'b1);

    // req pulses while busy and during DONE are dropped
    exp_q.push_back(8'hC3);
    run_txn(1'b1, 8'h66, 8'h99, 8'h00, 50, 1'b0, 1'b1);
    check_txn("pulse", LAT_A, T_PW, T_GAP, 1'b1);

    // req held high: back-to-back with one IDLE cycle between
    @(negedge clk);
    if_a.wr = 1'b1; if_a.address = 8'h55; if_a.data_wr = 8'hAA;
    if_a.req = 1'b1;
    b2b_done = 0; b2b_second = 0; b2b_idle = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      if (if_a.done) begin
        b2b_done++;
        if (b2b_done == 2) b2b_second = c;
      end
      if (!if_a.busy) b2b_idle++;
    end
    if_a.req = 1'b0;
    check("b2b done_count", b2b_done, 2);
    check("b2b second_done", b2b_second, 2 * LAT_A + 1);
    check("b2b idle_cycles", b2b_idle, 2);
    drained = 1'b0;
    for (int c = 0; c < 40 && !drained; c++) begin
      @(negedge clk);
      if (!if_a.busy && !if_a.done) drained = 1'b1;
    end
    check("b2b drain", drained, 1);
    check("b2b data_rd", if_a.data_rd, 8'hC3);

    // asynchronous reset during write data strobe
    @(negedge clk);
    if_a.wr = 1'b1; if_a.address = 8'h12; if_a.data_wr = 8'h34;
    if_a.req = 1'b1;
    @(negedge clk);
    if_a.req = 1'b0;
    repeat (15) @(negedge clk);
    check("mid state D_PW", a_state, 6);
    check("mid wr_n low", a_wr_n, 0);
    #1 Reset = 1'b0;
    #1;
    check("async reset pins", {a_cs_n, a_wr_n, a_rd_n, a_a_d, if_a.busy, if_a.done}, 6'b111100);
    check("async reset data_rd", if_a.data_rd, 8'h00);
    @(negedge clk);
    Reset = 1'b1;
    exp_q.push_back(8'h00);
    run_txn(1'b1, 8'h0A, 8'h5B, 8'h00, 30, 1'b0, 1'b0);
    check_txn("post_reset", LAT_A, T_PW, T_GAP, 1'b1);

    // clamped-timing DUT
    sel = 1'b1;
    exp_q.push_back(8'h5A);
    run_txn(1'b0, 8'h21, 8'h86, 8'h5A, 14, 1'b0, 1'b0);
    check_txn("clamp_rd", LAT_B, 1, 1, 1'b0);
    exp_q.push_back(8'h5A);
    run_txn(1'b1, 8'h30, 8'h07, 8'h00, 14, 1'b0, 1'b0);
    check_txn("clamp_wr", LAT_B, 1, 1, 1'b1);

    check("bus rules", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/rtc_bus_controller.md
Name: rtc_bus_controller

Overview:
- Responder end of the RTC register-access requests produced by the timer and clock control FSMs (address plus data, write or read).
- Runs each request as one two-phase transaction on the RTC's multiplexed address/data bus. The address phase is always a write strobe; the data phase is a write or a read.
- Sits between the control FSMs and the top-level RTC pins.
- Returns read data with a one-cycle done pulse.

Parameters:
- T_SU, 2, setup cycles per phase, bus driven and cs_n low before the strobe.
- T_PW, 4, strobe-low cycles per phase.
- T_HD, 2, hold cycles per phase after the strobe rises.
- T_GAP, 4, idle cycles between the address and data phases (cs_n high).
- CNT_W, 8, phase counter width. Each T_* must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- Reset  in  1  reset, asynchronous, active-low: 0 resets, 1 runs.
- req  in  1  request strobe, sampled only in IDLE.
- wr  in  1  1 = write transaction, 0 = read transaction; latched on accept.
- address  in  8  RTC register address; latched on accept.
- data_wr  in  8  write data; latched on accept.
- data_rd  out  8  read result; updated only by reads.
- busy  out  1  high from the accept edge until done falls.
- done  out  1  one-cycle completion pulse.
- cs_n  out  1  RTC chip select, active low.
- a_d  out  1  0 = address phase, 1 = data phase.
- wr_n  out  1  write strobe, active low.
- rd_n  out  1  read strobe, active low.
- ad  inout  8  multiplexed bus. Driven only in the windows below, otherwise 8'hZZ.

Behaviour:
- Reset (Reset=0, asynchronous, including mid-transaction):
  - state IDLE; cs_n=1, a_d=1, wr_n=1, rd_n=1, ad=Z.
  - busy=0, done=0, data_rd=8'h00; latched fields cleared.
- Parameter clamping: a T_* value of 0 is treated as 1, so every state lasts at least one cycle.
- All pin outputs are registered, with no combinational path from req to the pins.
- States and outputs, in order:
  - IDLE: pins at reset values. If req=1, latch wr/address/data_wr, set busy=1 and go to A_SU.
  - A_SU, T_SU cycles: cs_n=0, a_d=0, ad=address.
  - A_PW, T_PW cycles: as A_SU plus wr_n=0.
  - A_HD, T_HD cycles: wr_n=1; cs_n=0, a_d=0, ad=address held.
  - GAP, T_GAP cycles: cs_n=1, a_d=1, ad=Z.
  - D_SU, T_SU cycles: cs_n=0, a_d=1; ad=data_wr if write, Z if read.
  - D_PW, T_PW cycles: as D_SU plus wr_n=0 (write) or rd_n=0 (read). On a read, ad is sampled into data_rd at the clock edge that ends the last D_PW cycle.
  - D_HD, T_HD cycles: strobes high; cs_n=0; write data held on ad.
  - DONE, 1 cycle: pins at idle values, done=1, busy=1. Next state IDLE, with busy=0 and done=0.
- Latency: accept edge to done rising is 2·(T_SU+T_PW+T_HD)+T_GAP+1 cycles. With defaults, done is high in cycle 21 and busy lasts 21 cycles.
- Strobe exclusivity:
  - wr_n and rd_n are never both low.
  - A strobe is never low while cs_n=1.
  - a_d changes only while both strobes are high.
- Requests:
  - req while busy (including the DONE cycle) is ignored and not queued.
  - A req held high across DONE is accepted on the first IDLE cycle, giving back-to-back transactions with one IDLE cycle between them.
  - Input changes after accept have no effect on the current transaction.
- A write transaction leaves data_rd unchanged.

Decomposition:
- Package rtc_bus_pkg holds:
  - state encoding localparams (IDLE, A_SU, A_PW, A_HD, GAP, D_SU, D_PW, D_HD, DONE);
  - default timing constants;
  - a_d phase encodings (ADDR_PHASE=0, DATA_PHASE=1).
- One sub-module, phase_timer:
  - loadable CNT_W down-counter;
  - inputs: load, load_value (clamped to ≥1);
  - output: expire, high in the last cycle of a state.
  - The FSM reloads it on every state entry.

Test Plan:
- Reset, then idle 10 cycles: cs_n=1, wr_n=1, rd_n=1, a_d=1, ad=Z, busy=0, done=0, data_rd=8'h00.
- Write, defaults (wr=1, address=8'h00, data_wr=8'h10, one-cycle req):
  - ad=8'h00 with a_d=0 and wr_n low for 4 cycles;
  - 4-cycle gap with cs_n high;
  - ad=8'h10 with a_d=1 and wr_n low for 4 cycles;
  - done high exactly in cycle 21 after accept; data_rd unchanged.
- Read (wr=0, address=8'h21), bench RTC model drives ad=8'h59 during rd_n low:
  - rd_n low for 4 cycles, ad released by the DUT in the data phase;
  - data_rd=8'h59 when done rises.
- Back-to-back and ignored requests:
  - req held high for 50 cycles: two transactions separated by one IDLE cycle.
  - req pulse while busy: no extra transaction.
  - Input change mid-transaction: the latched address still appears on ad.
- Reset mid-transaction: assert Reset=0 during the D_PW cycles of a write. All pins return to idle values asynchronously, before the next clock edge, and busy=0. After release, a new request completes normally.
- Parameter sweep T_SU=0, T_PW=1, T_HD=0, T_GAP=0 (clamped to 1): done in cycle 2·3+1+1=8. Strobe exclusivity and a_d-change rules checked by assertions throughout.
